// File: rtl/lfsr_stream_cipher.sv
// rtl/lfsr_stream_cipher.sv - word-wide LFSR stream cipher (out = in ^ keystream) with valid/ready handshakes
// Define LFSR_STREAM_CIPHER_PARALLEL_EN to generate a whole keystream word in one cycle.
module lfsr_stream_cipher #(
  parameter int                  LFSR_W     = 16,
  parameter int                  DATA_W     = 8,
  parameter logic [LFSR_W-1:0]   TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0]   RESET_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] semente,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_OUT} state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                rdy_q;

`ifdef LFSR_STREAM_CIPHER_PARALLEL_EN
  logic [LFSR_W-1:0]   par_lfsr;
  logic [DATA_W-1:0]   par_ks;

  // Unrolled chain: same bit order as the serial path, MSB of the word first.
  always_comb begin
    par_lfsr = lfsr_q;
    par_ks   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      par_ks[DATA_W-1-i] = par_lfsr[LFSR_W-1];
      par_lfsr           = {par_lfsr[LFSR_W-2:0], ^(par_lfsr & TAPS)};
    end
  end
`else
  localparam int                 CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W-1:0]  MSB_ONE = DATA_W'(1) << (DATA_W - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LFSR_W-1:0]   lfsr_step;
  logic [DATA_W-1:0]   bit_mask;

  assign lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign bit_mask  = MSB_ONE >> cnt_q;
`endif

  assign in_ready  = rdy_q && (state_q == ST_IDLE) && !load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifndef LFSR_STREAM_CIPHER_PARALLEL_EN
    cnt_d       = cnt_q;
`endif
    if (load) begin
      // An all-zero seed would lock the LFSR, so it is replaced by all ones.
      lfsr_d      = (semente == '0) ? '1 : semente;
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            work_d  = in_data;
`ifndef LFSR_STREAM_CIPHER_PARALLEL_EN
            cnt_d   = '0;
`endif
            state_d = ST_GEN;
          end
        end
        ST_GEN: begin
`ifdef LFSR_STREAM_CIPHER_PARALLEL_EN
          lfsr_d      = par_lfsr;
          work_d      = work_q ^ par_ks;
          out_data_d  = work_d;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
`else
          lfsr_d = lfsr_step;
          work_d = work_q ^ (lfsr_q[LFSR_W-1] ? bit_mask : '0);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            out_data_d  = work_d;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end
`endif
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= RESET_SEED;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= 1'b1;
    end
  end

`ifndef LFSR_STREAM_CIPHER_PARALLEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// tb/tb_lfsr_stream_cipher.sv - randomized self-checking bench for lfsr_stream_cipher against a keystream model
module tb_lfsr_stream_cipher;

  localparam logic [15:0] TAPS       = 16'hB400;
  localparam logic [15:0] RESET_SEED = 16'hACE1;
`ifdef LFSR_STREAM_CIPHER_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] semente = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned model_lfsr;
  logic [7:0]  last_out;

  always #5 clk = ~clk;

  lfsr_stream_cipher dut (
    .clk(clk), .rst_n(rst_n), .load(load), .semente(semente),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference keystream: next bit is the register's top bit; feedback is the parity of the tapped bits.
  function automatic logic [7:0] model_word();
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      w = {w[6:0], model_lfsr[15]};
      model_lfsr = ((model_lfsr << 1) | ($countones(model_lfsr & TAPS) % 2)) & 32'hFFFF;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] seed);
    load    = 1'b1;
    semente = seed;
    #1;
    check_eq("in_ready_during_load", 32'(in_ready), 32'd0);
    tick();
    load = 1'b0;
    model_lfsr = (seed == 16'h0) ? 32'hFFFF : 32'(seed);
  endtask

  task automatic send_word(input logic [7:0] d, input int hold);
    logic [7:0] exp;
    int n = 0;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    exp = d ^ model_word();
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("latency", 32'(n), 32'(LAT));
    check_eq("out_data", 32'(out_data), 32'(exp));
    last_out = out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(out_data), 32'(exp));
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("valid_drop", 32'(out_valid), 32'd0);
    check_eq("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic start_and_abort(input logic [7:0] d, input bit use_reset, input logic [15:0] seed);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < ((LAT > 3) ? 3 : 0); i++) tick();
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_busy", 32'(busy), 32'd0);
      check_eq("async_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      model_lfsr = 32'(RESET_SEED);
    end else begin
      do_load(seed);
    end
    for (int i = 0; i < 10; i++) begin
      check_eq("abort_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
  endtask

  initial begin
    #2;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    model_lfsr = 32'(RESET_SEED);
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_word(8'h00, 0);
    check_eq("reset_seed_word", 32'(last_out), 32'hAC);

    do_load(16'hF0A5);
    send_word(8'h54, 0);
    check_eq("enc_word0", 32'(last_out), 32'hA4);
    send_word(8'h65, 5);
    check_eq("enc_word1", 32'(last_out), 32'hC0);

    do_load(16'hF0A5);
    send_word(8'hA4, 0);
    check_eq("dec_word0", 32'(last_out), 32'h54);
    send_word(8'hC0, 0);
    check_eq("dec_word1", 32'(last_out), 32'h65);

    do_load(16'h0000);
    send_word(8'h00, 0);
    check_eq("zero_seed_word", 32'(last_out), 32'hFF);

    wait_ready();
    load = 1'b1; semente = 16'h1234; in_valid = 1'b1; in_data = 8'h5A;
    tick();
    load = 1'b0; in_valid = 1'b0;
    model_lfsr = 32'h1234;
    check_eq("load_beats_valid", 32'(busy), 32'd0);
    send_word(8'h5A, 2);

    start_and_abort(8'h33, 1'b0, 16'hF0A5);
    send_word(8'h54, 0);
    check_eq("after_load_abort", 32'(last_out), 32'hA4);
    start_and_abort(8'h77, 1'b1, 16'h0);
    send_word(8'h00, 0);
    check_eq("after_rst_abort", 32'(last_out), 32'hAC);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0)
        do_load(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      send_word(8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
